// File: rtl/bidir_shift_buffer.sv
// bidir_shift_buffer: DEPTH x DATA_WIDTH shift buffer, shiftable right or left,
// with parallel load, synchronous clear, per-entry valid bits, registered
// occupancy count / full / empty, and a registered drop-out port.
// Optional rotate mode is compiled in when BIDIR_SHIFT_BUFFER_ROTATE_EN is defined.
module bidir_shift_buffer #(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 5,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic [DEPTH*DATA_WIDTH-1:0] load_data,
  input  logic                        clear,
  input  logic                        load,
  input  logic                        shift,
  input  logic                        direction_right,
  input  logic                        rotate,
  output logic [DEPTH*DATA_WIDTH-1:0] out,
  output logic [DEPTH-1:0]            valid,
  output logic [CNT_W-1:0]            count,
  output logic                        full,
  output logic                        empty,
  output logic [DATA_WIDTH-1:0]       dropped,
  output logic                        dropped_valid
);

  logic [DATA_WIDTH-1:0] ent_q [DEPTH];
  logic [DATA_WIDTH-1:0] ent_d [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [DATA_WIDTH-1:0] dropped_q, dropped_d;
  logic                  dv_q, dv_d;
  logic                  rotate_active;

`ifdef BIDIR_SHIFT_BUFFER_ROTATE_EN
  assign rotate_active = rotate;
`else
  // Rotate is not built: the input is deliberately left dangling.
  logic unused_rotate;
  assign unused_rotate = rotate;
  assign rotate_active = 1'b0;
`endif

  // Next-state: clear beats load beats shift; the count tracks the valid vector
  // by adding one whenever a shift brings in data without losing a valid entry.
  always_comb begin
    logic [DATA_WIDTH-1:0] outgoing_data;
    logic                  outgoing_valid;
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    valid_d        = valid_q;
    count_d        = count_q;
    dropped_d      = dropped_q;
    dv_d           = 1'b0;
    outgoing_data  = '0;
    outgoing_valid = 1'b0;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      valid_d = '0;
      count_d = '0;
    end else if (load) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = load_data[i*DATA_WIDTH +: DATA_WIDTH];
      valid_d = '1;
      count_d = CNT_W'(DEPTH);
    end else if (shift) begin
      if (direction_right) begin
        outgoing_data  = ent_q[0];
        outgoing_valid = valid_q[0];
        for (int i = 0; i < DEPTH - 1; i++) begin
          ent_d[i]   = ent_q[i+1];
          valid_d[i] = valid_q[i+1];
        end
        ent_d[DEPTH-1]   = rotate_active ? outgoing_data : data_in;
        valid_d[DEPTH-1] = rotate_active ? outgoing_valid : 1'b1;
      end else begin
        outgoing_data  = ent_q[DEPTH-1];
        outgoing_valid = valid_q[DEPTH-1];
        for (int i = 1; i < DEPTH; i++) begin
          ent_d[i]   = ent_q[i-1];
          valid_d[i] = valid_q[i-1];
        end
        ent_d[0]   = rotate_active ? outgoing_data : data_in;
        valid_d[0] = rotate_active ? outgoing_valid : 1'b1;
      end
      if (!rotate_active) begin
        dropped_d = outgoing_data;
        dv_d      = outgoing_valid;
        if (!outgoing_valid) count_d = count_q + CNT_W'(1);
      end
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  // State register with synchronous reset overriding any command.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      valid_q   <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      dropped_q <= '0;
      dv_q      <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      valid_q   <= valid_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      dropped_q <= dropped_d;
      dv_q      <= dv_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign out[g*DATA_WIDTH +: DATA_WIDTH] = ent_q[g];
  end

  assign valid         = valid_q;
  assign count         = count_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign dropped       = dropped_q;
  assign dropped_valid = dv_q;

endmodule
